stk_alloc_sched: RTL and testbench
==================================

Name: stk_alloc_sched

Overview:
- Client-side scheduler for the banked descriptor stack allocator (stk_pipe_al).
- Shares one allocation port and one descriptor-return port among CLIENTS_N requesters, using round-robin on each.
- Tracks the free-descriptor count and per-client outstanding quota, so allocations are only admitted when a descriptor is guaranteed.
- Routes the lookup-stage pointer back to the winning client one cycle after grant.

Parameters:
- CLIENTS_N, 4, number of requesting clients (≥2).
- LINES_N, stk_pkg::LINES_N, total descriptors held by the allocator after init.
- QUOTA_N, 8, maximum outstanding (allocated, not returned) descriptors per client.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- i_cl_alloc_req  in  CLIENTS_N  per-client allocation request (level)
- o_cl_alloc_gnt  out  CLIENTS_N  one-hot grant, combinational, same cycle as request
- o_cl_ptr_vld_r  out  CLIENTS_N  one-hot: pointer returned to that client this cycle
- o_cl_ptr  out  stk_pkg::PTR_W  returned pointer (valid with o_cl_ptr_vld_r)
- i_cl_dealloc_vld  in  CLIENTS_N  per-client return valid
- i_cl_dealloc_ptr  in  CLIENTS_N x PTR_W  per-client returned pointer
- o_cl_dealloc_rdy  out  CLIENTS_N  one-hot return accept
- o_ad_alloc  out  1  to allocator i_ad_alloc
- i_ad_busy  in  1  allocator initialising
- o_dealloc_vld  out  1  to allocator i_dealloc_vld
- o_dealloc_ptr  out  stk_pkg::ptr_t  to allocator i_dealloc_ptr
- i_lk_ptr_w  in  stk_pkg::ptr_t  allocator lookup-stage pointer
- o_busy_r  out  1  scheduler not yet in RUN

Behaviour:
- Reset values: o_busy_r=1. All other outputs 0. free_cnt_r=0, per-client out_cnt_r=0, lk_vld_r=0, FSM=INIT, both rr pointers at client 0.
- FSM:
  - INIT: no grants, no dealloc accepts. On i_ad_busy==0 -> load free_cnt_r=LINES_N, go to RUN, o_busy_r->0 next cycle.
  - RUN: free_cnt_r!=0.
  - EMPTY: free_cnt_r==0.
  - RUN->EMPTY when the next count is 0. EMPTY->RUN when the next count is nonzero.
  - i_ad_busy asserting in RUN/EMPTY is a protocol error (assertion); no recovery required.
- Dealloc path:
  - Eligible clients are those with i_cl_dealloc_vld, in RUN/EMPTY only.
  - rr picks at most one per cycle; o_cl_dealloc_rdy is one-hot to the winner.
  - o_dealloc_vld/o_dealloc_ptr are driven combinationally from the winner.
  - The winner's out_cnt decrements. Returns are never back-pressured by alloc traffic.
- Alloc path:
  - A client is eligible if it has i_cl_alloc_req and out_cnt_r<QUOTA_N.
  - Global admit = (free_cnt_r!=0) | o_dealloc_vld. The same-cycle return is bypassed by the allocator's collision path.
  - rr picks one eligible client when admit is true. o_cl_alloc_gnt and o_ad_alloc=|gnt fire in the same cycle; the winner's out_cnt increments.
- Counters:
  - free_cnt_next = free_cnt_r + o_dealloc_vld - o_ad_alloc, width clog2(LINES_N+1).
  - Alloc and dealloc in the same cycle leave the count unchanged.
  - Overflow above LINES_N or underflow below 0 is an assertion failure.
  - For out_cnt, alloc and return by the same client in the same cycle cancel.
  - A return from a client whose out_cnt==0 is an assertion failure; the count saturates at 0.
- Response:
  - lk_vld_r<=o_ad_alloc and lk_cl_r<=winner id.
  - Next cycle: o_cl_ptr_vld_r = lk_vld_r ? onehot(lk_cl_r) : 0, and o_cl_ptr = i_lk_ptr_w.
  - Latency is exactly 1 cycle from grant. Back-to-back grants yield back-to-back responses.
- rr pointers advance only on an accepted grant (ack = any gnt).
- Async reset mid-operation: all state clears immediately and the FSM restarts in INIT. In-flight lk responses are dropped.

Decomposition:
- stk_pkg gains:
  - CLIENTS_N;
  - client_id_t = logic [clog2(CLIENTS_N)-1:0];
  - FREE_CNT_W;
  - QUOTA_N;
  - enum sched_state_t {INIT, RUN, EMPTY}.
- Reuse the existing rr (two instances) and enc/dec.
- One natural sub-module: stk_alloc_sched_quota, the per-client outstanding counters plus eligibility mask (generate over CLIENTS_N).

Test Plan:
- Init: hold i_ad_busy=1 for 20 cycles while client 0 requests -> no gnt, o_busy_r=1. Busy drops -> RUN, free_cnt=LINES_N, first gnt next cycle, ptr on o_cl_ptr_vld_r[0] one cycle later.
- Fairness: all 4 clients request continuously -> grants rotate 0,1,2,3,0. Each response is one-hot to the matching client 1 cycle after its grant.
- Exhaustion: LINES_N=16, QUOTA_N=16, client 0 requests 17 times -> 16 grants, then EMPTY with no gnt. Client 0 returns 1 pointer -> same-cycle gnt via bypass, free_cnt stays 0.
- Quota: QUOTA_N=2, client 2 requests continuously -> 2 grants, then blocked while clients 0/1 still receive grants. Client 2 returns 1 -> exactly one further grant.
- Collision: in the same cycle, client 1 alloc and client 3 dealloc -> o_ad_alloc=1, o_dealloc_vld=1, free_cnt unchanged, client 1 receives the client 3 pointer value.
- Reset mid-run: assert arst_n low with lk_vld_r=1 -> no o_cl_ptr_vld_r, all counters 0, FSM=INIT, o_busy_r=1.

Source files
------------

// File: rtl/stk_alloc_sched_pkg.sv
// Shared types and defaults for the descriptor-stack client scheduler.
// Pointer width follows the allocator's line count.
package stk_alloc_sched_pkg;
  localparam int LINES_N    = 16;
  localparam int PTR_W      = $clog2(LINES_N);
  typedef logic [PTR_W-1:0] ptr_t;

  localparam int CLIENTS_N  = 4;
  typedef logic [$clog2(CLIENTS_N)-1:0] client_id_t;

  localparam int FREE_CNT_W = $clog2(LINES_N + 1);
  localparam int QUOTA_N    = 8;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    EMPTY = 2'd2
  } sched_state_t;
endpackage

// File: rtl/stk_alloc_sched_quota.sv
// Per-client outstanding-descriptor counters and the resulting alloc eligibility mask.
// A client is eligible while it requests and holds fewer than QUOTA_N descriptors.
module stk_alloc_sched_quota #(
  parameter int CLIENTS_N = 4,
  parameter int QUOTA_N   = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [CLIENTS_N-1:0] req,
  input  logic [CLIENTS_N-1:0] alloc,
  input  logic [CLIENTS_N-1:0] dealloc,
  output logic [CLIENTS_N-1:0] elig,
  output logic                 idle
);
  localparam int CNT_W = $clog2(QUOTA_N + 1);

  logic [CLIENTS_N-1:0] zero;

  for (genvar g = 0; g < CLIENTS_N; g++) begin : g_cl
    logic [CNT_W-1:0] cnt_r;

    // Same-cycle alloc and return by one client cancel; returns saturate at zero.
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        cnt_r <= '0;
      end else begin
        case ({alloc[g], dealloc[g]})
          2'b10:   cnt_r <= cnt_r + 1'b1;
          2'b01:   if (cnt_r != '0) cnt_r <= cnt_r - 1'b1;
          default: cnt_r <= cnt_r;
        endcase
      end
    end

    assign elig[g] = req[g] && (cnt_r < CNT_W'(QUOTA_N));
    assign zero[g] = (cnt_r == '0);

    a_no_return_at_zero: assert property (@(posedge clk) disable iff (!arst_n)
      dealloc[g] |-> (cnt_r != '0));
    a_no_alloc_over_quota: assert property (@(posedge clk) disable iff (!arst_n)
      alloc[g] |-> (cnt_r < CNT_W'(QUOTA_N)));
  end

  assign idle = &zero;
endmodule

// File: rtl/stk_alloc_sched.sv
// Round-robin scheduler sharing one alloc port and one return port of the descriptor
// allocator among CLIENTS_N clients, admitting allocs only when a descriptor is guaranteed.
module stk_alloc_sched
  import stk_alloc_sched_pkg::*;
#(
  parameter int CLIENTS_N = stk_alloc_sched_pkg::CLIENTS_N,
  parameter int LINES_N   = stk_alloc_sched_pkg::LINES_N,
  parameter int QUOTA_N   = stk_alloc_sched_pkg::QUOTA_N
) (
  input  logic                                    clk,
  input  logic                                    arst_n,
  input  logic [CLIENTS_N-1:0]                    i_cl_alloc_req,
  output logic [CLIENTS_N-1:0]                    o_cl_alloc_gnt,
  output logic [CLIENTS_N-1:0]                    o_cl_ptr_vld_r,
  output stk_alloc_sched_pkg::ptr_t               o_cl_ptr,
  input  logic [CLIENTS_N-1:0]                    i_cl_dealloc_vld,
  input  stk_alloc_sched_pkg::ptr_t [CLIENTS_N-1:0] i_cl_dealloc_ptr,
  output logic [CLIENTS_N-1:0]                    o_cl_dealloc_rdy,
  output logic                                    o_ad_alloc,
  input  logic                                    i_ad_busy,
  output logic                                    o_dealloc_vld,
  output stk_alloc_sched_pkg::ptr_t               o_dealloc_ptr,
  input  stk_alloc_sched_pkg::ptr_t               i_lk_ptr_w,
  output logic                                    o_busy_r,
  output stk_alloc_sched_pkg::sched_state_t       o_dbg_state,
  output logic [$clog2(LINES_N+1)-1:0]            o_dbg_free_cnt,
  output logic                                    o_dbg_out_idle
);
  localparam int CID_W = $clog2(CLIENTS_N);
  localparam int FW    = $clog2(LINES_N + 1);
  typedef logic [CID_W-1:0] cid_t;

  // Handshakes: a request/return stays asserted until its one-hot gnt/rdy is seen in
  // the same cycle; gnt/rdy never fire without the matching request/valid.

  function automatic cid_t rr_pick(input logic [CLIENTS_N-1:0] req, input cid_t ptr);
    cid_t pick;
    cid_t idx;
    logic found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < CLIENTS_N; i++) begin
      idx = cid_t'((int'(ptr) + i) % CLIENTS_N);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  function automatic logic [CLIENTS_N-1:0] onehot(input cid_t id);
    return CLIENTS_N'(1) << id;
  endfunction

  function automatic cid_t rr_next(input cid_t id);
    return (id == cid_t'(CLIENTS_N - 1)) ? '0 : id + 1'b1;
  endfunction

  sched_state_t         state_r, state_nxt;
  logic [FW-1:0]        free_cnt_r, free_nxt, free_d;
  cid_t                 a_ptr_r, d_ptr_r, a_win, d_win, lk_cl_r;
  logic                 lk_vld_r, running, admit;
  logic [CLIENTS_N-1:0] d_elig, a_elig, a_cand;

  assign running = (state_r != INIT);

  // Return path: never blocked by alloc traffic.
  assign d_elig           = running ? i_cl_dealloc_vld : '0;
  assign d_win            = rr_pick(d_elig, d_ptr_r);
  assign o_dealloc_vld    = |d_elig;
  assign o_cl_dealloc_rdy = o_dealloc_vld ? onehot(d_win) : '0;
  assign o_dealloc_ptr    = o_dealloc_vld ? i_cl_dealloc_ptr[d_win] : '0;

  stk_alloc_sched_quota #(
    .CLIENTS_N (CLIENTS_N),
    .QUOTA_N   (QUOTA_N)
  ) u_quota (
    .clk     (clk),
    .arst_n  (arst_n),
    .req     (i_cl_alloc_req),
    .alloc   (o_cl_alloc_gnt),
    .dealloc (o_cl_dealloc_rdy),
    .elig    (a_elig),
    .idle    (o_dbg_out_idle)
  );

  // A same-cycle return counts as a free descriptor: the allocator bypasses it.
  assign admit          = (free_cnt_r != '0) || o_dealloc_vld;
  assign a_cand         = running ? a_elig : '0;
  assign a_win          = rr_pick(a_cand, a_ptr_r);
  assign o_cl_alloc_gnt = (admit && (|a_cand)) ? onehot(a_win) : '0;
  assign o_ad_alloc     = |o_cl_alloc_gnt;

  assign free_nxt = free_cnt_r + FW'(o_dealloc_vld) - FW'(o_ad_alloc);

  always_comb begin
    state_nxt = state_r;
    free_d    = free_cnt_r;
    case (state_r)
      INIT: begin
        if (!i_ad_busy) begin
          state_nxt = RUN;
          free_d    = FW'(LINES_N);
        end
      end
      RUN, EMPTY: begin
        free_d    = free_nxt;
        state_nxt = (free_nxt == '0) ? EMPTY : RUN;
      end
      default: begin
        state_nxt = INIT;
        free_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r    <= INIT;
      free_cnt_r <= '0;
      o_busy_r   <= 1'b1;
      a_ptr_r    <= '0;
      d_ptr_r    <= '0;
      lk_vld_r   <= 1'b0;
      lk_cl_r    <= '0;
    end else begin
      state_r    <= state_nxt;
      free_cnt_r <= free_d;
      o_busy_r   <= (state_nxt == INIT);
      if (o_ad_alloc)    a_ptr_r <= rr_next(a_win);
      if (o_dealloc_vld) d_ptr_r <= rr_next(d_win);
      lk_vld_r   <= o_ad_alloc;
      lk_cl_r    <= a_win;
    end
  end

  assign o_cl_ptr_vld_r = lk_vld_r ? onehot(lk_cl_r) : '0;
  assign o_cl_ptr       = lk_vld_r ? i_lk_ptr_w : '0;

  assign o_dbg_state    = state_r;
  assign o_dbg_free_cnt = free_cnt_r;

  a_busy_only_in_init: assert property (@(posedge clk) disable iff (!arst_n)
    running |-> !i_ad_busy);
  a_free_no_overflow: assert property (@(posedge clk) disable iff (!arst_n)
    running |-> !((free_cnt_r == FW'(LINES_N)) && o_dealloc_vld && !o_ad_alloc));
  a_free_no_underflow: assert property (@(posedge clk) disable iff (!arst_n)
    running |-> !((free_cnt_r == '0) && o_ad_alloc && !o_dealloc_vld));
endmodule

// File: tb/tb_stk_alloc_sched.sv
// Directed bench for stk_alloc_sched: stimulus pushes expected responses, a negedge
// monitor pops them whenever a pointer is returned to a client.
module tb_stk_alloc_sched;
  import stk_alloc_sched_pkg::*;

  localparam int N  = 4;
  localparam int QN = 5;
  localparam int FW = $clog2(16 + 1);

  logic            clk = 1'b0;
  logic            arst_n;
  logic [N-1:0]    i_cl_alloc_req, o_cl_alloc_gnt, o_cl_ptr_vld_r;
  logic [N-1:0]    i_cl_dealloc_vld, o_cl_dealloc_rdy;
  ptr_t            o_cl_ptr, o_dealloc_ptr, i_lk_ptr_w;
  ptr_t [N-1:0]    i_cl_dealloc_ptr;
  logic            o_ad_alloc, i_ad_busy, o_dealloc_vld, o_busy_r, o_dbg_out_idle;
  sched_state_t    o_dbg_state;
  logic [FW-1:0]   o_dbg_free_cnt;

  always #5 clk = ~clk;

  stk_alloc_sched #(.CLIENTS_N(N), .LINES_N(16), .QUOTA_N(QN)) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .i_cl_alloc_req   (i_cl_alloc_req),
    .o_cl_alloc_gnt   (o_cl_alloc_gnt),
    .o_cl_ptr_vld_r   (o_cl_ptr_vld_r),
    .o_cl_ptr         (o_cl_ptr),
    .i_cl_dealloc_vld (i_cl_dealloc_vld),
    .i_cl_dealloc_ptr (i_cl_dealloc_ptr),
    .o_cl_dealloc_rdy (o_cl_dealloc_rdy),
    .o_ad_alloc       (o_ad_alloc),
    .i_ad_busy        (i_ad_busy),
    .o_dealloc_vld    (o_dealloc_vld),
    .o_dealloc_ptr    (o_dealloc_ptr),
    .i_lk_ptr_w       (i_lk_ptr_w),
    .o_busy_r         (o_busy_r),
    .o_dbg_state      (o_dbg_state),
    .o_dbg_free_cnt   (o_dbg_free_cnt),
    .o_dbg_out_idle   (o_dbg_out_idle)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  logic [5:0] exp_q[$];   // {client id, pointer}
  ptr_t       dptr [N]    = '{4'd5, 4'd6, 4'd9, 4'd10};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] id_of(input logic [N-1:0] oh);
    logic [1:0] id;
    id = '0;
    for (int i = 0; i < N; i++) if (oh[i]) id = 2'(i);
    return id;
  endfunction

  task automatic chk_state(input string name, input sched_state_t st, input int free,
                           input logic busy, input logic idle);
    cmp({name, " state"}, 32'(o_dbg_state), 32'(st));
    cmp({name, " free"},  32'(o_dbg_free_cnt), 32'(free));
    cmp({name, " busy"},  32'(o_busy_r), 32'(busy));
    cmp({name, " idle"},  32'(o_dbg_out_idle), 32'(idle));
  endtask

  // One cycle: apply inputs, check the combinational grant/accept, then act as the
  // allocator's lookup stage (bypassed return pointer on collision, else a cycle tag).
  task automatic vec(input string name, input logic [N-1:0] req, input logic [N-1:0] dvld,
                     input logic [N-1:0] egnt, input logic [N-1:0] edrdy, input bit rsp);
    ptr_t nxt;
    ptr_t eptr;
    i_cl_alloc_req   = req;
    i_cl_dealloc_vld = dvld;
    @(negedge clk);
    cmp({name, " gnt"},      32'(o_cl_alloc_gnt), 32'(egnt));
    cmp({name, " drdy"},     32'(o_cl_dealloc_rdy), 32'(edrdy));
    cmp({name, " ad_alloc"}, 32'(o_ad_alloc), 32'(|egnt));
    cmp({name, " d_vld"},    32'(o_dealloc_vld), 32'(|edrdy));
    if (edrdy != '0) cmp({name, " d_ptr"}, 32'(o_dealloc_ptr), 32'(dptr[id_of(edrdy)]));
    if (egnt != '0 && rsp) begin
      eptr = (edrdy != '0) ? dptr[id_of(edrdy)] : ptr_t'(cyc);
      exp_q.push_back({id_of(egnt), eptr});
    end
    nxt = o_ad_alloc ? (o_dealloc_vld ? o_dealloc_ptr : ptr_t'(cyc)) : '0;
    @(posedge clk);
    #1;
    i_lk_ptr_w = nxt;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (o_cl_ptr_vld_r != '0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got vld %b want none", o_cl_ptr_vld_r);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        cmp("rsp vld", 32'(o_cl_ptr_vld_r), 32'(4'b0001 << e[5:4]));
        cmp("rsp ptr", 32'(o_cl_ptr), 32'(e[3:0]));
      end
    end
  end

  initial begin
    arst_n           = 1'b0;
    i_ad_busy        = 1'b1;
    i_cl_alloc_req   = '0;
    i_cl_dealloc_vld = '0;
    i_lk_ptr_w       = '0;
    for (int c = 0; c < N; c++) i_cl_dealloc_ptr[c] = dptr[c];

    #12;
    chk_state("reset", INIT, 0, 1'b1, 1'b1);
    cmp("reset gnt", 32'(o_cl_alloc_gnt), 32'(0));
    cmp("reset ptr_vld", 32'(o_cl_ptr_vld_r), 32'(0));
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    // Allocator initialising: no grants despite a request.
    for (int i = 0; i < 20; i++) vec("init_hold", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
    chk_state("init_hold", INIT, 0, 1'b1, 1'b1);
    i_ad_busy = 1'b0;
    vec("init_done", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
    chk_state("init_done", RUN, 16, 1'b0, 1'b1);
    vec("first", 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1);

    // Fairness: rotation continues after client 0.
    vec("fair0", 4'b1111, 4'b0000, 4'b0010, 4'b0000, 1);
    vec("fair1", 4'b1111, 4'b0000, 4'b0100, 4'b0000, 1);
    vec("fair2", 4'b1111, 4'b0000, 4'b1000, 4'b0000, 1);
    vec("fair3", 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1);
    vec("fair4", 4'b1111, 4'b0000, 4'b0010, 4'b0000, 1);
    chk_state("fair", RUN, 10, 1'b0, 1'b0);

    // Quota: client 2 tops out at QN, others keep being served.
    for (int i = 0; i < 4; i++) vec("quota_c2", 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1);
    chk_state("quota_c2", RUN, 6, 1'b0, 1'b0);
    vec("quota_block", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1);
    vec("quota_oth0", 4'b0111, 4'b0000, 4'b0001, 4'b0000, 1);
    vec("quota_oth1", 4'b0111, 4'b0000, 4'b0010, 4'b0000, 1);
    vec("quota_oth2", 4'b0111, 4'b0000, 4'b0001, 4'b0000, 1);
    vec("quota_oth3", 4'b0111, 4'b0000, 4'b0010, 4'b0000, 1);
    vec("quota_ret", 4'b0000, 4'b0100, 4'b0000, 4'b0100, 1);
    chk_state("quota_ret", RUN, 3, 1'b0, 1'b0);
    vec("quota_again", 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1);
    vec("quota_reblock", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1);

    // Exhaustion, then bypass of a same-cycle return.
    vec("exh0", 4'b1000, 4'b0000, 4'b1000, 4'b0000, 1);
    vec("exh1", 4'b1000, 4'b0000, 4'b1000, 4'b0000, 1);
    chk_state("exh", EMPTY, 0, 1'b0, 1'b0);
    vec("empty_block", 4'b1011, 4'b0000, 4'b0000, 4'b0000, 1);
    vec("bypass", 4'b1000, 4'b0001, 4'b1000, 4'b0001, 1);
    chk_state("bypass", EMPTY, 0, 1'b0, 1'b0);
    vec("collide", 4'b0010, 4'b1000, 4'b0010, 4'b1000, 1);
    chk_state("collide", EMPTY, 0, 1'b0, 1'b0);
    vec("ret_only", 4'b0000, 4'b1000, 4'b0000, 4'b1000, 1);
    chk_state("ret_only", RUN, 1, 1'b0, 1'b0);

    // Reset while a lookup response is in flight: it must be dropped.
    vec("pre_reset", 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0);
    arst_n         = 1'b0;
    i_cl_alloc_req = '0;
    #1;
    cmp("rst_drop ptr_vld", 32'(o_cl_ptr_vld_r), 32'(0));
    chk_state("rst_mid", INIT, 0, 1'b1, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    vec("reinit", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
    chk_state("reinit", RUN, 16, 1'b0, 1'b1);
    vec("post_reset", 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1);
    vec("drain0", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    vec("drain1", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    cmp("queue drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
